mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 175 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Fixed 33-cycle latency from accept to the one-cycle done pulse.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] RS1data_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic [4:0]      RDaddr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      RDaddr_o,
    output logic            RegWrite_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_rd;
    logic [4:0]      r_rd_out;
    logic [CW-1:0]   r_cnt;
    logic            r_fin;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_result;

    function automatic logic f_sa(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    endfunction

    function automatic logic f_sb(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    endfunction

    function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    logic [XLEN-1:0] w_in_amag;
    logic [XLEN-1:0] w_in_bmag;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_pneg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_addend;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;
    logic [XLEN-1:0] w_mul_hi;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_final;

    assign w_in_amag = f_mag(RS1data_i, f_sa(funct3_i));
    assign w_in_bmag = f_mag(RS2data_i, f_sb(funct3_i));

    assign w_a_neg = f_sa(r_op) & r_a[XLEN-1];
    assign w_b_neg = f_sb(r_op) & r_b[XLEN-1];
    assign w_pneg  = w_a_neg ^ w_b_neg;
    assign w_a_mag = w_a_neg ? -r_a : r_a;
    assign w_b_mag = w_b_neg ? -r_b : r_b;

    // Multiply step: conditional add into the high half, then shift right.
    assign w_addend = r_lo[0] ? w_a_mag : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

    // Divide step: shift in next dividend bit, subtract if it fits.
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_ge     = w_rem_sh >= {1'b0, w_b_mag};
    assign w_sub    = w_rem_sh[XLEN-1:0] - w_b_mag;

    // High word of the negated product: ~hi plus carry out of ~lo + 1.
    assign w_mul_hi = w_pneg ? (~r_hi + {{(XLEN-1){1'b0}}, (r_lo == '0)}) : r_hi;
    assign w_quot   = (r_b == '0) ? '1 : (w_pneg ? -r_lo : r_lo);
    assign w_rem    = w_a_neg ? -r_hi : r_hi;

    always_comb begin
        w_final = w_rem;
        case (r_op)
            3'b000:                 w_final = r_lo;
            3'b001, 3'b010, 3'b011: w_final = w_mul_hi;
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start_i) w_next = S_CALC;
            S_CALC:  if (r_fin) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (r_state != S_IDLE);
        done_o     = (r_state == S_DONE);
        RegWrite_o = (r_state == S_DONE) && (r_rd_out != 5'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_rd_out <= '0;
            r_cnt    <= '0;
            r_fin    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op  <= funct3_i;
                        r_a   <= RS1data_i;
                        r_b   <= RS2data_i;
                        r_rd  <= RDaddr_i;
                        r_cnt <= '0;
                        r_fin <= 1'b0;
                        r_hi  <= '0;
                        r_lo  <= funct3_i[2] ? w_in_amag : w_in_bmag;
                    end
                end
                S_CALC: begin
                    if (!r_fin) begin
                        if (r_op[2]) begin
                            r_hi <= w_ge ? w_sub : w_rem_sh[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_ge};
                        end else begin
                            r_hi <= w_sum[XLEN:1];
                            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) r_fin <= 1'b1;
                    end else begin
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                        r_fin    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign RDaddr_o = r_rd_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit.
// Each task drives one scenario and checks the outputs inline.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rdaddr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rdout;
    logic        regw;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.XLEN(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .funct3_i   (funct3),
        .RS1data_i  (rs1),
        .RS2data_i  (rs2),
        .RDaddr_i   (rdaddr),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .RDaddr_o   (rdout),
        .RegWrite_o (regw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string nm,
                         input int inj);
        int lat;
        int pulses;
        logic regw_at_done;
        lat = 0;
        pulses = 0;
        regw_at_done = 1'b0;
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rdaddr = rd;
        @(posedge clk); #1;
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom;
        funct3 = 3'($urandom); rdaddr = 5'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = (k == inj);
            if (k == inj) begin
                funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rdaddr = 5'd9;
            end
            if (done) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    regw_at_done = regw;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL %s latency: got %0d want 33", nm, lat);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d want 1", nm, pulses);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", nm, result, exp);
        end
        checks++;
        if (rdout !== rd) begin
            errors++;
            $display("FAIL %s RDaddr_o: got %0d want %0d", nm, rdout, rd);
        end
        checks++;
        if (regw_at_done !== (rd != 5'd0)) begin
            errors++;
            $display("FAIL %s RegWrite_o: got %b want %b", nm, regw_at_done, (rd != 5'd0));
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after: got %b want 0", nm, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; rdaddr = 5'd1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, regw} !== 3'b000) begin
            errors++;
            $display("FAIL reset flags: got %b want 000", {busy, done, regw});
        end
        checks++;
        if (result !== 32'd0 || rdout !== 5'd0) begin
            errors++;
            $display("FAIL reset regs: got %h/%0d want 0/0", result, rdout);
        end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset start priority: busy got %b want 0", busy);
        end
    endtask

    task automatic test_mul;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "MUL", 0);
        do_op(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, "MUL_rd0", 0);
    endtask

    task automatic test_mulh;
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, "MULH", 0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, "MULHU", 0);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, "MULHSU", 0);
    endtask

    task automatic test_div;
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, "DIV", 0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, "REM", 0);
        do_op(3'b101, 32'd100, 32'd7, 5'd12, 32'd14, "DIVU", 0);
        do_op(3'b111, 32'd100, 32'd7, 5'd13, 32'd2, "REMU", 0);
    endtask

    task automatic test_div_special;
        do_op(3'b101, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, "DIVU_by0", 0);
        do_op(3'b110, 32'd5, 32'd0, 5'd15, 32'd5, "REM_by0", 0);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd16, 32'hFFFF_FFFF, "DIV_neg_by0", 0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, "DIV_ovf", 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, "REM_ovf", 0);
    endtask

    task automatic test_ignore_start;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "MUL_ignore", 3);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rdaddr = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || result !== 32'd14) begin
            errors++;
            $display("FAIL b2b first: done %b result %h want 1 %h", done, result, 32'd14);
        end
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; rdaddr = 5'd0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b start in DONE: busy got %b want 0", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || result !== 32'd14) begin
            errors++;
            $display("FAIL b2b accept/hold: busy %b result %h want 1 %h", busy, result, 32'd14);
        end
        repeat (32) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b early done: got %b want 0", done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || result !== 32'd12 || regw !== 1'b0) begin
            errors++;
            $display("FAIL b2b second: done %b result %h regw %b want 1 %h 0",
                     done, result, regw, 32'd12);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        int pulses;
        pulses = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b011; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; rdaddr = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, regw} !== 3'b000) begin
            errors++;
            $display("FAIL abort flags: got %b want 000", {busy, done, regw});
        end
        checks++;
        if (result !== 32'd0 || rdout !== 5'd0) begin
            errors++;
            $display("FAIL abort regs: got %h/%0d want 0/0", result, rdout);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || regw) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort pulses: got %0d want 0", pulses);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        funct3 = 3'b000;
        rs1 = '0;
        rs2 = '0;
        rdaddr = '0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
